// File: rtl/id_reg_file.sv
// id_reg_file -- 31x32-bit register file with per-register pending-write
// scoreboard for an in-order issue stage.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   WBRd/WBData/WBRegWrite   writeback write port (write-through to reads)
//   IDRs/IDRt           combinational read addresses (A/B)
//   IDUseRs/IDUseRt     issuing instruction actually reads Rs/Rt
//   IDIssue             issue request
//   IDIssueWrite/IDIssueRd   issuing instruction's destination register
//   IDRsData/IDRtData   read data (r0 reads 0)
//   IDStall             issue blocked by RAW hazard or saturated counter
//   SBError             sticky: writeback seen with nothing pending
module id_reg_file (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  WBRd,
  input  logic [31:0] WBData,
  input  logic        WBRegWrite,
  input  logic [4:0]  IDRs,
  input  logic [4:0]  IDRt,
  input  logic        IDUseRs,
  input  logic        IDUseRt,
  input  logic        IDIssue,
  input  logic        IDIssueWrite,
  input  logic [4:0]  IDIssueRd,
  output logic [31:0] IDRsData,
  output logic [31:0] IDRtData,
  output logic        IDStall,
  output logic        SBError
);

  logic [31:0] regs_q [1:31];
  logic [1:0]  pend_q [1:31];
  logic [1:0]  pend_d [1:31];
  logic        sb_error_q;
  logic        sb_error_d;

  logic        wb_active_s;
  logic [1:0]  rs_eff_s;
  logic [1:0]  rt_eff_s;
  logic        rd_full_s;
  logic        stall_s;
  logic        accept_s;

  // Bypass is suppressed during reset so reads show only stored contents.
  assign wb_active_s = WBRegWrite & ~Reset;

  // Read port A: r0 is hardwired zero, otherwise write-through bypass.
  always_comb begin
    IDRsData = 32'd0;
    if (IDRs == 5'd0) begin
      IDRsData = 32'd0;
    end else if (wb_active_s && (WBRd == IDRs)) begin
      IDRsData = WBData;
    end else begin
      IDRsData = regs_q[IDRs];
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    IDRtData = 32'd0;
    if (IDRt == 5'd0) begin
      IDRtData = 32'd0;
    end else if (wb_active_s && (WBRd == IDRt)) begin
      IDRtData = WBData;
    end else begin
      IDRtData = regs_q[IDRt];
    end
  end

  // Hazard detection: a source hazard uses the count net of this cycle's
  // retire, so the last pending write clears the stall as it lands.
  always_comb begin
    rs_eff_s  = 2'd0;
    rt_eff_s  = 2'd0;
    rd_full_s = 1'b0;
    if (IDUseRs && (IDRs != 5'd0)) begin
      if (WBRegWrite && (WBRd == IDRs) && (pend_q[IDRs] != 2'd0)) begin
        rs_eff_s = pend_q[IDRs] - 2'd1;
      end else begin
        rs_eff_s = pend_q[IDRs];
      end
    end else begin
      rs_eff_s = 2'd0;
    end
    if (IDUseRt && (IDRt != 5'd0)) begin
      if (WBRegWrite && (WBRd == IDRt) && (pend_q[IDRt] != 2'd0)) begin
        rt_eff_s = pend_q[IDRt] - 2'd1;
      end else begin
        rt_eff_s = pend_q[IDRt];
      end
    end else begin
      rt_eff_s = 2'd0;
    end
    // A saturated counter can still take a new issue if one retires now.
    if (IDIssueWrite && (IDIssueRd != 5'd0) && (pend_q[IDIssueRd] == 2'd3)) begin
      rd_full_s = ~(WBRegWrite && (WBRd == IDIssueRd));
    end else begin
      rd_full_s = 1'b0;
    end
  end

  assign stall_s  = IDIssue & ~Reset &
                    ((rs_eff_s != 2'd0) | (rt_eff_s != 2'd0) | rd_full_s);
  assign accept_s = IDIssue & ~stall_s;
  assign IDStall  = stall_s;
  assign SBError  = sb_error_q;

  // Pending-counter next state: increment on accepted write-issue,
  // decrement on retire, hold when both or neither happen.
  always_comb begin
    for (int i = 1; i < 32; i++) begin
      if ((accept_s && IDIssueWrite && (IDIssueRd == 5'(i))) &&
          !(WBRegWrite && (WBRd == 5'(i)) && (pend_q[i] != 2'd0))) begin
        pend_d[i] = pend_q[i] + 2'd1;
      end else if (!(accept_s && IDIssueWrite && (IDIssueRd == 5'(i))) &&
                   (WBRegWrite && (WBRd == 5'(i)) && (pend_q[i] != 2'd0))) begin
        pend_d[i] = pend_q[i] - 2'd1;
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
  end

  // Sticky error: writeback to a register with no outstanding issue.
  always_comb begin
    sb_error_d = sb_error_q;
    if (WBRegWrite && (WBRd != 5'd0) && (pend_q[WBRd] == 2'd0)) begin
      sb_error_d = 1'b1;
    end else begin
      sb_error_d = sb_error_q;
    end
  end

  // State update; reset discards any same-cycle writeback or issue.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= 32'd0;
        pend_q[i] <= 2'd0;
      end
      sb_error_q <= 1'b0;
    end else begin
      if (WBRegWrite && (WBRd != 5'd0)) begin
        regs_q[WBRd] <= WBData;
      end
      for (int i = 1; i < 32; i++) begin
        pend_q[i] <= pend_d[i];
      end
      sb_error_q <= sb_error_d;
    end
  end

endmodule

// File: doc/id_reg_file.md
ID_REG_FILE -- requirements
Module: id_reg_file

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-002 Ports (name  direction  width  meaning):
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous active-high reset
- WBRd  in  5  writeback destination register
- WBData  in  32  writeback data
- WBRegWrite  in  1  writeback enable
- IDRs  in  5  read port A address
- IDRt  in  5  read port B address
- IDUseRs  in  1  issuing instruction reads Rs
- IDUseRt  in  1  issuing instruction reads Rt
- IDIssue  in  1  ID requests issue of the current instruction
- IDIssueWrite  in  1  issuing instruction writes a register
- IDIssueRd  in  5  destination of the issuing instruction
- IDRsData  out  32  read port A data
- IDRtData  out  32  read port B data
- IDStall  out  1  issue blocked this cycle
- SBError  out  1  sticky: writeback arrived with no pending issue

Function
REQ-003 Storage SHALL be 31 writable 32-bit registers (1..31); register 0 SHALL always read 0.
REQ-004 A write SHALL take effect on the posedge where WBRegWrite=1 and WBRd!=0: regs[WBRd]<=WBData; writes with WBRd=0 SHALL be discarded.
REQ-005 Reads SHALL be combinational: address 0 -> 0; else, if WBRegWrite=1 and WBRd equals the address, WBData (write-through bypass); else the stored value.
REQ-006 Each register 1..31 SHALL have a 2-bit pending counter Pend[i], range 0..3.
REQ-007 Issue is accepted ("Accept") when IDIssue=1 and IDStall=0.
REQ-008 "Retire[i]" SHALL mean WBRegWrite=1, WBRd=i, i!=0, Pend[i]!=0.
REQ-009 On posedge: Accept with IDIssueWrite=1, IDIssueRd=i!=0, and no Retire[i] -> Pend[i]+1; Retire[i] without such an Accept -> Pend[i]-1; both in the same cycle -> Pend[i] unchanged.
REQ-010 Effective count Eff[i] SHALL be Pend[i] minus 1 when Retire[i] holds this cycle, else Pend[i].
REQ-011 IDStall SHALL be 1 iff IDIssue=1 and Reset=0 and any of:
- IDUseRs=1, IDRs!=0, Eff[IDRs]!=0
- IDUseRt=1, IDRt!=0, Eff[IDRt]!=0
- IDIssueWrite=1, IDIssueRd!=0, Pend[IDIssueRd]=3 and no Retire[IDIssueRd]
REQ-012 The same-cycle retire of the last pending write SHALL clear the hazard; the bypassed WBData SHALL be the value read.
REQ-013 A WB write with WBRd!=0 and Pend[WBRd]=0 SHALL still update data, leave Pend at 0, and set SBError=1 on the next posedge; SBError SHALL remain 1 until Reset.
REQ-014 Pend SHALL never wrap: increments at 3 are prevented by REQ-011; decrements at 0 are prevented by REQ-008.
REQ-015 IDIssue=0 SHALL leave all Pend unchanged except for retires, and SHALL force IDStall=0.

Reset
REQ-016 On a posedge with Reset=1: all registers <=0, all Pend <=0, SBError <=0; WB writes and issues in that cycle SHALL be ignored.
REQ-017 While Reset=1, IDStall SHALL be 0; IDRsData/IDRtData SHALL show stored values only, with the bypass disabled.
REQ-018 Reset asserted with writes pending SHALL discard them; a later WB write to such a register SHALL set SBError.

Verification
REQ-019 Bench SHALL cover the following scenarios:
- Write/read: WB writes r5=0xDEADBEEF; next cycle IDRs=5 -> IDRsData=0xDEADBEEF. A WB write to r0=0x1234 -> r0 reads 0 and SBError stays 0.
- Bypass: WBRegWrite=1, WBRd=7, WBData=0xA5A5A5A5 with IDRt=7 in the same cycle -> IDRtData=0xA5A5A5A5 combinationally.
- RAW stall: issue writing r3; next cycle issue with IDRs=3, IDUseRs=1 -> IDStall=1; the cycle WB writes r3=0x42 -> IDStall=0 and IDRsData=0x42.
- Saturation: three accepted issues to r9 with no WB -> Pend[9]=3; fourth issue to r9 -> IDStall=1; same cycle as a WB to r9 -> accepted, Pend stays 3.
- Error/reset: WB to r12 with Pend[12]=0 -> r12 updated and SBError=1 next cycle; Reset for 1 cycle -> all reads 0, SBError=0, IDStall=0.
